// File: rtl/soc_mgmt_rst_req_agent.sv
// Partition-side reset request/acknowledge agent: quiesce, request, track generator ack.
// Optional quiesce timeout enabled by defining SOC_MGMT_RST_REQ_TIMEOUT_EN.
module soc_mgmt_rst_req_agent #(
   parameter int TIMEOUTW       = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int MIN_REQ_CYCLES = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sw_req,
   input  logic                i_idle,
   input  logic [TIMEOUTW-1:0] i_timeout_cycles,
   input  logic                i_timeout_clr,
   output logic                o_quiesce_req,
   output logic                o_rst_req_n,
   output logic                o_rst_ip_ack,
   input  logic                i_rst_ack_n,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_ext_rst,
   output logic                o_timeout
);

   localparam int HOLDW = (MIN_REQ_CYCLES > 1) ? $clog2(MIN_REQ_CYCLES) : 1;
   localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MIN_REQ_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      QUIESCE,
      REQ,
      WAIT_ACK,
      HOLD
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic [HOLDW-1:0]       hold_cnt;
   logic                   tmo_expired;

   // Synchronizer idles high so a reset release never looks like a generator ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_sync <= '1;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_rst_ack_n};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef SOC_MGMT_RST_REQ_TIMEOUT_EN
   logic [TIMEOUTW-1:0] tmo_cnt;
   logic                tmo_flag;
   logic                tmo_set;

   assign tmo_expired = (tmo_cnt == '0);
   assign tmo_set     = (state == QUIESCE) && ack_s && !i_idle && tmo_expired;

   // Counter is reloaded every IDLE cycle, so it holds the budget on QUIESCE entry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (state == IDLE) begin
            tmo_cnt <= i_timeout_cycles;
         end else if ((state == QUIESCE) && !tmo_expired) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
         if (tmo_set) begin
            tmo_flag <= 1'b1;
         end else if (i_timeout_clr) begin
            tmo_flag <= 1'b0;
         end
      end
   end

   assign o_timeout = tmo_flag;
`else
   logic unused_tmo_inputs;

   assign unused_tmo_inputs = ^{i_timeout_cycles, i_timeout_clr};
   assign tmo_expired       = 1'b0;
   assign o_timeout         = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         o_quiesce_req <= 1'b0;
         o_rst_req_n   <= 1'b1;
         o_rst_ip_ack  <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_ext_rst     <= 1'b0;
      end else begin
         o_done    <= 1'b0;
         o_ext_rst <= 1'b0;
         case (state)
            IDLE: begin
               // An unrequested reset takes priority over a same-cycle software request.
               if (!ack_s) begin
                  state         <= HOLD;
                  o_ext_rst     <= 1'b1;
                  o_rst_ip_ack  <= 1'b1;
                  o_quiesce_req <= 1'b1;
                  o_busy        <= 1'b1;
               end else if (i_sw_req) begin
                  state         <= QUIESCE;
                  o_quiesce_req <= 1'b1;
                  o_busy        <= 1'b1;
               end
            end
            QUIESCE: begin
               if (!ack_s) begin
                  state        <= HOLD;
                  o_rst_ip_ack <= 1'b1;
               end else if (i_idle || tmo_expired) begin
                  state        <= REQ;
                  hold_cnt     <= '0;
                  o_rst_req_n  <= 1'b0;
                  o_rst_ip_ack <= 1'b1;
               end
            end
            REQ: begin
               if (hold_cnt == HOLD_LAST) begin
                  if (!ack_s) begin
                     state       <= HOLD;
                     o_rst_req_n <= 1'b1;
                  end else begin
                     state <= WAIT_ACK;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            WAIT_ACK: begin
               if (!ack_s) begin
                  state       <= HOLD;
                  o_rst_req_n <= 1'b1;
               end
            end
            HOLD: begin
               if (ack_s) begin
                  state         <= IDLE;
                  o_quiesce_req <= 1'b0;
                  o_rst_ip_ack  <= 1'b0;
                  o_busy        <= 1'b0;
                  o_done        <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_mgmt_rst_req_agent.sv
// Scoreboard bench for soc_mgmt_rst_req_agent; timeout cases follow SOC_MGMT_RST_REQ_TIMEOUT_EN.
module tb_soc_mgmt_rst_req_agent;

   localparam int TIMEOUTW       = 16;
   localparam int SYNC_STAGES    = 2;
   localparam int MIN_REQ_CYCLES = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                sw_req = 1'b0;
   logic                idle = 1'b1;
   logic [TIMEOUTW-1:0] tmo_cycles = '0;
   logic                tmo_clr = 1'b0;
   logic                rst_ack_n = 1'b1;
   logic                quiesce_req, rst_req_n, rst_ip_ack, busy, done, ext_rst, timeout;

   soc_mgmt_rst_req_agent #(
      .TIMEOUTW      (TIMEOUTW),
      .SYNC_STAGES   (SYNC_STAGES),
      .MIN_REQ_CYCLES(MIN_REQ_CYCLES)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_sw_req        (sw_req),
      .i_idle          (idle),
      .i_timeout_cycles(tmo_cycles),
      .i_timeout_clr   (tmo_clr),
      .o_quiesce_req   (quiesce_req),
      .o_rst_req_n     (rst_req_n),
      .o_rst_ip_ack    (rst_ip_ack),
      .i_rst_ack_n     (rst_ack_n),
      .o_busy          (busy),
      .o_done          (done),
      .o_ext_rst       (ext_rst),
      .o_timeout       (timeout)
   );

   always #5 clk = ~clk;

   // One entry per expected completed sequence (o_done pulse).
   typedef struct {
      int q_len;
      int low_len;
      int ext_cnt;
      int tmo;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_req();
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
   endtask

   task automatic wait_fall(input int bound);
      int k = 0;
      while (rst_req_n && k < bound) begin
         tick();
         k++;
      end
      check("rst_req_fall_seen", rst_req_n, 0);
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (busy && k < bound) begin
         tick();
         k++;
      end
      check("return_to_idle", busy, 0);
   endtask

   // Generator model: ack sampled low d_low edges after the request falls, released d_high later.
   task automatic gen(input int d_low, input int d_high);
      wait_fall(200);
      tick(d_low - 1);
      rst_ack_n = 1'b0;
      tick(d_high);
      rst_ack_n = 1'b1;
      wait_idle(100);
   endtask

   // Monitor: measure each sequence and compare against the queue on o_done.
   initial begin
      int  m_q, m_low, m_ext;
      bit  m_seen_ack, m_drop;
      ev_t e;
      m_q = 0; m_low = 0; m_ext = 0; m_seen_ack = 0; m_drop = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_q = 0; m_low = 0; m_ext = 0; m_seen_ack = 0; m_drop = 0;
         end else begin
            if (quiesce_req && rst_req_n && !rst_ip_ack) m_q++;
            if (!rst_req_n) m_low++;
            if (ext_rst) m_ext++;
            if (busy && m_seen_ack && !rst_ip_ack) m_drop = 1;
            if (rst_ip_ack) m_seen_ack = 1;
            if (done) begin
               check("done_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("seq_quiesce_cycles", m_q, e.q_len);
                  check("seq_rst_req_low_cycles", m_low, e.low_len);
                  check("seq_ext_rst_pulses", m_ext, e.ext_cnt);
                  check("seq_timeout_flag", int'(timeout), e.tmo);
                  check("seq_ip_ack_held", int'(m_drop), 0);
               end
               m_q = 0; m_low = 0; m_ext = 0; m_seen_ack = 0; m_drop = 0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      tick(3);
      check("rst_quiesce_req", quiesce_req, 0);
      check("rst_rst_req_n", rst_req_n, 1);
      check("rst_ip_ack", rst_ip_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ext_rst", ext_rst, 0);
      check("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      tick(2);

      // Normal sequence: ack low 10 cycles after request falls, released 20 later
      idle = 1'b1;
      exp_q.push_back(ev_t'{1, 10 + SYNC_STAGES, 0, 0});
      pulse_req();
      check("norm_quiesce_next_cycle", quiesce_req, 1);
      check("norm_busy_next_cycle", busy, 1);
      check("norm_req_not_yet", rst_req_n, 1);
      gen(10, 20);
      tick(2);

`ifdef SOC_MGMT_RST_REQ_TIMEOUT_EN
      // Timeout with budget 5: REQ six cycles after QUIESCE entry
      idle = 1'b0;
      tmo_cycles = 16'd5;
      exp_q.push_back(ev_t'{6, 5, 0, 1});
      pulse_req();
      gen(3, 4);
      tick(2);
      check("timeout_sticky", timeout, 1);
      tmo_clr = 1'b1;
      tick();
      tmo_clr = 1'b0;
      check("timeout_cleared", timeout, 0);

      // Set and clear in the same cycle: set wins
      exp_q.push_back(ev_t'{6, 5, 0, 1});
      pulse_req();
      tick(5);
      check("timeout_no_req_early", rst_req_n, 1);
      tmo_clr = 1'b1;
      tick();
      tmo_clr = 1'b0;
      check("timeout_set_wins", timeout, 1);
      check("timeout_req_entry", rst_req_n, 0);
      gen(3, 4);
      tick(2);
      tmo_clr = 1'b1;
      tick();
      tmo_clr = 1'b0;

      // Zero budget: REQ right after the first QUIESCE cycle
      tmo_cycles = 16'd0;
      exp_q.push_back(ev_t'{1, 5, 0, 1});
      pulse_req();
      gen(3, 4);
      tick(2);
      tmo_clr = 1'b1;
      tick();
      tmo_clr = 1'b0;
      check("timeout_zero_cleared", timeout, 0);
      idle = 1'b1;
`endif

      // External reset: generator ack low for 8 cycles while IDLE
      exp_q.push_back(ev_t'{0, 0, 1, 0});
      rst_ack_n = 1'b0;
      tick(3);
      check("ext_pulse", ext_rst, 1);
      check("ext_ip_ack", rst_ip_ack, 1);
      check("ext_req_stays_high", rst_req_n, 1);
      tick();
      check("ext_pulse_single", ext_rst, 0);
      tick(4);
      rst_ack_n = 1'b1;
      wait_idle(50);
      tick(2);

      // Collision: request lands on the cycle the external reset is seen
      exp_q.push_back(ev_t'{0, 0, 1, 0});
      rst_ack_n = 1'b0;
      tick(2);
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      check("coll_ext_pulse", ext_rst, 1);
      check("coll_no_req", rst_req_n, 1);
      check("coll_ip_ack", rst_ip_ack, 1);
      tick();
      pulse_req();
      check("ignore_busy", busy, 1);
      check("ignore_no_req", rst_req_n, 1);
      tick(3);
      rst_ack_n = 1'b1;
      wait_idle(50);
      tick(6);
      check("ignore_not_queued", busy, 0);

      // Minimum pulse: ack one cycle after the request falls
      exp_q.push_back(ev_t'{1, MIN_REQ_CYCLES, 0, 0});
      pulse_req();
      gen(1, 10);
      tick(2);

      // Reset mid-sequence in WAIT_ACK
      pulse_req();
      wait_fall(20);
      tick(5);
      check("mid_in_wait_ack", rst_req_n, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_quiesce_req", quiesce_req, 0);
      check("mid_rst_rst_req_n", rst_req_n, 1);
      check("mid_rst_ip_ack", rst_ip_ack, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ext_rst", ext_rst, 0);
      check("mid_rst_timeout", timeout, 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("mid_restart_idle", busy, 0);
      check("mid_restart_req_n", rst_req_n, 1);

`ifndef SOC_MGMT_RST_REQ_TIMEOUT_EN
      // No timeout hardware: QUIESCE waits indefinitely for idle
      idle = 1'b0;
      pulse_req();
      tick(1000);
      check("notmo_still_quiesce", quiesce_req, 1);
      check("notmo_no_req", rst_req_n, 1);
      check("notmo_busy", busy, 1);
      check("notmo_timeout_zero", timeout, 0);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      idle = 1'b1;
      tick(2);
`endif

      tick(5);
      check("all_sequences_completed", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
